// File: rtl/mp_regfile_rr_pkg.sv
// Shared defaults and helpers for the multi-port round-robin register file.
// Every address/pointer width in the slice comes from clog2_min1.
package mp_regfile_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_NUM_WR = 2;

  // Widths never collapse to zero bits, even for a depth or port count of 1 or 2.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mp_regfile_rr_if.sv
// Read port and arbitrated write ports of mp_regfile_rr grouped as one bundle.
// The master drives requests; the slave is the register file.
interface mp_regfile_rr_if
  import mp_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = clog2_min1(DEF_DEPTH),
  parameter int NUM_WR = DEF_NUM_WR
);

  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic [DATA_W-1:0]        rd_data;
  logic                     rd_valid;
  logic                     rd_err;

  logic [NUM_WR-1:0]        wr_valid;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic [NUM_WR-1:0]        wr_ready;
  logic                     wr_err;

  modport master (
    output rd_en, rd_addr, wr_valid, wr_addr, wr_data,
    input  rd_data, rd_valid, rd_err, wr_ready, wr_err
  );

  modport slave (
    input  rd_en, rd_addr, wr_valid, wr_addr, wr_data,
    output rd_data, rd_valid, rd_err, wr_ready, wr_err
  );

endinterface

// File: rtl/mp_regfile_rr_arb.sv
// Combinational round-robin arbiter: scans req starting at ptr and grants
// the first requester. The rotating pointer itself lives in the parent.
module rr_arbiter
  import mp_regfile_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any_grant
);

  function automatic logic [PW-1:0] slot(input logic [PW-1:0] p, input int k);
    return PW'((int'(p) + k) % N);
  endfunction

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any_grant && req[slot(ptr, k)]) begin
        any_grant = 1'b1;
        grant_idx = slot(ptr, k);
      end
    end
    if (any_grant) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/mp_regfile_rr.sv
// DEPTH x DATA_W register file: one registered read port, NUM_WR write ports
// sharing a single write slot per cycle under round-robin arbitration.
module mp_regfile_rr
  import mp_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = clog2_min1(DEPTH),
  parameter int NUM_WR = DEF_NUM_WR
) (
  input logic            clk,
  input logic            reset,
  mp_regfile_rr_if.slave bus
);

  localparam int PW = clog2_min1(NUM_WR);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_err_q, rd_err_d;
  logic              wr_err_q, wr_err_d;

  logic [NUM_WR-1:0] grant;
  logic [PW-1:0]     grant_idx;
  logic              any_grant;
  logic [ADDR_W-1:0] wr_addr_sel;
  logic [DATA_W-1:0] wr_data_sel;
  logic              wr_in_range;
  logic              wr_fire;
  logic              rd_in_range;

  rr_arbiter #(
    .N  (NUM_WR),
    .PW (PW)
  ) u_arb (
    .req       (bus.wr_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign bus.wr_ready = grant;

  always_comb begin
    wr_addr_sel = '0;
    wr_data_sel = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (grant_idx == PW'(i)) begin
        wr_addr_sel = bus.wr_addr[i*ADDR_W +: ADDR_W];
        wr_data_sel = bus.wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // An out-of-range write still consumes its grant so the pointer keeps rotating.
  assign wr_in_range = (int'(wr_addr_sel) < DEPTH);
  assign wr_fire     = any_grant && wr_in_range;
  assign rd_in_range = (int'(bus.rd_addr) < DEPTH);

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_grant) begin
      rr_ptr_d = (int'(grant_idx) == NUM_WR - 1) ? '0 : grant_idx + PW'(1);
    end
    wr_err_d   = any_grant && !wr_in_range;
    rd_valid_d = bus.rd_en;
    rd_err_d   = bus.rd_en && !rd_in_range;
    rd_data_d  = rd_data_q;
    if (bus.rd_en) begin
      rd_data_d = rd_in_range ? mem_q[bus.rd_addr] : '0;
    end
  end

  // Reads sample mem_q before this edge's write lands, giving read-old-data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_fire) begin
      mem_q[wr_addr_sel] <= wr_data_sel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_err   = rd_err_q;
  assign bus.wr_err   = wr_err_q;

endmodule

// File: tb/tb_mp_regfile_rr.sv
// Directed bench for mp_regfile_rr: a DEPTH=6/2-port instance and a
// DEPTH=8/4-port instance sharing one clock and reset.
module tb_mp_regfile_rr;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mp_regfile_rr_if #(.DATA_W(16), .ADDR_W(3), .NUM_WR(2)) bus_a ();
  mp_regfile_rr_if #(.DATA_W(16), .ADDR_W(3), .NUM_WR(4)) bus_b ();

  mp_regfile_rr #(.DATA_W(16), .DEPTH(6), .ADDR_W(3), .NUM_WR(2)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  mp_regfile_rr #(.DATA_W(16), .DEPTH(8), .ADDR_W(3), .NUM_WR(4)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input int p, input logic [2:0] a, input logic [15:0] d);
    bus_a.wr_addr[p*3 +: 3]   = a;
    bus_a.wr_data[p*16 +: 16] = d;
  endtask

  task automatic drive_b(input int p, input logic [2:0] a, input logic [15:0] d);
    bus_b.wr_addr[p*3 +: 3]   = a;
    bus_b.wr_data[p*16 +: 16] = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus_a.rd_data !== 16'h0000) begin errors++; $display("FAIL rst_rd_data got=%h exp=%h", bus_a.rd_data, 16'h0000); end
    checks++; if (bus_a.rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got=%b exp=0", bus_a.rd_valid); end
    checks++; if (bus_a.rd_err !== 1'b0) begin errors++; $display("FAIL rst_rd_err got=%b exp=0", bus_a.rd_err); end
    checks++; if (bus_a.wr_err !== 1'b0) begin errors++; $display("FAIL rst_wr_err got=%b exp=0", bus_a.wr_err); end
    reset = 1'b0;
    bus_a.rd_en = 1'b1; bus_a.rd_addr = 3'd3;
    tick();
    checks++; if (bus_a.rd_data !== 16'h0000) begin errors++; $display("FAIL rst_read_data got=%h exp=%h", bus_a.rd_data, 16'h0000); end
    checks++; if (bus_a.rd_valid !== 1'b1) begin errors++; $display("FAIL rst_read_valid got=%b exp=1", bus_a.rd_valid); end
    checks++; if (bus_a.rd_err !== 1'b0) begin errors++; $display("FAIL rst_read_err got=%b exp=0", bus_a.rd_err); end
    bus_a.rd_en = 1'b0;
  endtask

  task automatic test_single_port();
    bus_a.wr_valid = 2'b01; drive_a(0, 3'd2, 16'h1234);
    #1;
    checks++; if (bus_a.wr_ready !== 2'b01) begin errors++; $display("FAIL sp_ready0 got=%b exp=01", bus_a.wr_ready); end
    tick();
    checks++; if (bus_a.rd_valid !== 1'b0) begin errors++; $display("FAIL sp_idle_valid got=%b exp=0", bus_a.rd_valid); end
    bus_a.wr_valid = 2'b00; bus_a.rd_en = 1'b1; bus_a.rd_addr = 3'd2;
    tick();
    checks++; if (bus_a.rd_data !== 16'h1234) begin errors++; $display("FAIL sp_read0 got=%h exp=%h", bus_a.rd_data, 16'h1234); end
    bus_a.rd_en = 1'b0;
    bus_a.wr_valid = 2'b10; drive_a(1, 3'd2, 16'h5678);
    #1;
    checks++; if (bus_a.wr_ready !== 2'b10) begin errors++; $display("FAIL sp_ready1 got=%b exp=10", bus_a.wr_ready); end
    tick();
    bus_a.wr_valid = 2'b00; bus_a.rd_en = 1'b1; bus_a.rd_addr = 3'd2;
    tick();
    checks++; if (bus_a.rd_data !== 16'h5678) begin errors++; $display("FAIL sp_read1 got=%h exp=%h", bus_a.rd_data, 16'h5678); end
    bus_a.rd_en = 1'b0;
  endtask

  task automatic test_contention();
    logic [1:0] exp_g [4];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    bus_a.wr_valid = 2'b11;
    drive_a(0, 3'd1, 16'h7833);
    drive_a(1, 3'd1, 16'h1002);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (bus_a.wr_ready !== exp_g[k]) begin errors++; $display("FAIL cont2_grant%0d got=%b exp=%b", k, bus_a.wr_ready, exp_g[k]); end
      tick();
    end
    bus_a.wr_valid = 2'b00; bus_a.rd_en = 1'b1; bus_a.rd_addr = 3'd1;
    tick();
    checks++; if (bus_a.rd_data !== 16'h1002) begin errors++; $display("FAIL cont2_final got=%h exp=%h", bus_a.rd_data, 16'h1002); end
    bus_a.rd_en = 1'b0;
  endtask

  task automatic test_contention4();
    logic [3:0] exp_g [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int p = 0; p < 4; p++) drive_b(p, 3'd4, 16'hA000 + 16'(p));
    bus_b.wr_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (bus_b.wr_ready !== exp_g[k]) begin errors++; $display("FAIL cont4_grant%0d got=%b exp=%b", k, bus_b.wr_ready, exp_g[k]); end
      tick();
    end
    bus_b.wr_valid = 4'b0100;
    #1;
    checks++; if (bus_b.wr_ready !== 4'b0100) begin errors++; $display("FAIL cont4_solo got=%b exp=0100", bus_b.wr_ready); end
    tick();
    bus_b.wr_valid = 4'b1111;
    #1;
    checks++; if (bus_b.wr_ready !== 4'b1000) begin errors++; $display("FAIL cont4_ptr3 got=%b exp=1000", bus_b.wr_ready); end
    tick();
    bus_b.wr_valid = 4'b0000; bus_b.rd_en = 1'b1; bus_b.rd_addr = 3'd4;
    tick();
    checks++; if (bus_b.rd_data !== 16'hA003) begin errors++; $display("FAIL cont4_final got=%h exp=%h", bus_b.rd_data, 16'hA003); end
    checks++; if (bus_b.wr_err !== 1'b0) begin errors++; $display("FAIL cont4_wr_err got=%b exp=0", bus_b.wr_err); end
    bus_b.rd_en = 1'b0;
  endtask

  task automatic test_read_during_write();
    bus_a.wr_valid = 2'b01; drive_a(0, 3'd5, 16'h00AA);
    tick();
    bus_a.wr_valid = 2'b10; drive_a(1, 3'd5, 16'h00BB);
    bus_a.rd_en = 1'b1; bus_a.rd_addr = 3'd5;
    tick();
    checks++; if (bus_a.rd_data !== 16'h00AA) begin errors++; $display("FAIL rdw_old got=%h exp=%h", bus_a.rd_data, 16'h00AA); end
    bus_a.wr_valid = 2'b00;
    tick();
    checks++; if (bus_a.rd_data !== 16'h00BB) begin errors++; $display("FAIL rdw_new got=%h exp=%h", bus_a.rd_data, 16'h00BB); end
    bus_a.rd_en = 1'b0;
  endtask

  task automatic test_out_of_range();
    logic [15:0] exp_m [6];
    exp_m = '{16'h0000, 16'h1002, 16'h5678, 16'h0000, 16'h0000, 16'h00BB};
    bus_a.wr_valid = 2'b01; drive_a(0, 3'd7, 16'hDEAD);
    tick();
    checks++; if (bus_a.wr_err !== 1'b1) begin errors++; $display("FAIL oor_wr_err got=%b exp=1", bus_a.wr_err); end
    bus_a.wr_valid = 2'b00;
    tick();
    checks++; if (bus_a.wr_err !== 1'b0) begin errors++; $display("FAIL oor_wr_err_clr got=%b exp=0", bus_a.wr_err); end
    for (int a = 0; a < 6; a++) begin
      bus_a.rd_en = 1'b1; bus_a.rd_addr = 3'(a);
      tick();
      checks++; if (bus_a.rd_data !== exp_m[a]) begin errors++; $display("FAIL oor_mem%0d got=%h exp=%h", a, bus_a.rd_data, exp_m[a]); end
    end
    bus_a.rd_en = 1'b0;
    tick();
    checks++; if (bus_a.rd_data !== 16'h00BB || bus_a.rd_valid !== 1'b0) begin errors++; $display("FAIL oor_hold got=%h/%b exp=%h/0", bus_a.rd_data, bus_a.rd_valid, 16'h00BB); end
    bus_a.rd_en = 1'b1; bus_a.rd_addr = 3'd6;
    tick();
    checks++; if (bus_a.rd_data !== 16'h0000) begin errors++; $display("FAIL oor_rd_data got=%h exp=%h", bus_a.rd_data, 16'h0000); end
    checks++; if (bus_a.rd_err !== 1'b1) begin errors++; $display("FAIL oor_rd_err got=%b exp=1", bus_a.rd_err); end
    checks++; if (bus_a.rd_valid !== 1'b1) begin errors++; $display("FAIL oor_rd_valid got=%b exp=1", bus_a.rd_valid); end
    bus_a.rd_en = 1'b0;
    tick();
    checks++; if (bus_a.rd_err !== 1'b0) begin errors++; $display("FAIL oor_rd_err_clr got=%b exp=0", bus_a.rd_err); end
  endtask

  task automatic test_reset_midstream();
    bus_a.rd_en = 1'b1; bus_a.rd_addr = 3'd2;
    tick();
    checks++; if (bus_a.rd_data !== 16'h5678 || bus_a.rd_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got=%h/%b exp=%h/1", bus_a.rd_data, bus_a.rd_valid, 16'h5678); end
    bus_a.rd_addr = 3'd1;
    bus_a.wr_valid = 2'b01; drive_a(0, 3'd0, 16'h5555);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus_a.rd_data !== 16'h0000) begin errors++; $display("FAIL mid_rd_data got=%h exp=%h", bus_a.rd_data, 16'h0000); end
    checks++; if (bus_a.rd_valid !== 1'b0) begin errors++; $display("FAIL mid_rd_valid got=%b exp=0", bus_a.rd_valid); end
    checks++; if (bus_b.rd_data !== 16'h0000) begin errors++; $display("FAIL mid_b_rd_data got=%h exp=%h", bus_b.rd_data, 16'h0000); end
    tick();
    bus_a.wr_valid = 2'b00;
    bus_a.rd_en = 1'b0;
    reset = 1'b0;
    for (int a = 0; a < 3; a++) begin
      bus_a.rd_en = 1'b1; bus_a.rd_addr = 3'(a);
      tick();
      checks++; if (bus_a.rd_data !== 16'h0000) begin errors++; $display("FAIL mid_mem%0d got=%h exp=%h", a, bus_a.rd_data, 16'h0000); end
    end
    bus_a.rd_en = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus_a.rd_en = 1'b0; bus_a.rd_addr = '0; bus_a.wr_valid = '0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
    bus_b.rd_en = 1'b0; bus_b.rd_addr = '0; bus_b.wr_valid = '0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
    test_reset();
    test_single_port();
    test_contention();
    test_contention4();
    test_read_during_write();
    test_out_of_range();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
